pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline. Drives the keep (hold) and en (0 = flush to bubble)
//  controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and arbitrates the single instruction SRAM between
//  instruction fetch and MEM-stage data accesses. Resolves load-use and structural hazards, honours external
//  memory/UART wait, and counts lost fetch cycles.
// PARAMETERS
//  MEM_CYCLES  2        cycles a MEM-stage access holds the instruction SRAM (>=1)
//  IRAM_TOP    16'h8000 data addresses < IRAM_TOP hit the instruction SRAM (structural conflict)
// PORTS
//  pci_clk            in   1   clock (rising edge)
//  pci_rst            in   1   reset, asynchronous, active-low
//  pci_id_rreg1       in   4   ID-stage source reg 1 (`REG_INVALID = 4'hF when unused)
//  pci_id_rreg2       in   4   ID-stage source reg 2
//  pci_ex_wreg_addr   in   4   EX-stage destination reg
//  pci_ex_rwe         in   2   EX-stage mem op (`RWE_IDLE 00, `RWE_READ 01, `RWE_WRITE 10)
//  pci_mem_rwe        in   2   MEM-stage mem op
//  pci_mem_addr       in   16  MEM-stage data address
//  pci_mem_busy       in   1   external memory/UART not ready; freeze whole pipeline
//  pco_pc_keep        out  1   hold PC
//  pco_ifid_keep/en   out  1+1 IF/ID hold / not-flush
//  pco_idex_keep/en   out  1+1 ID/EX hold / not-flush
//  pco_exmem_keep/en  out  1+1 EX/MEM hold / not-flush
//  pco_memwb_en       out  1   MEM/WB not-flush (0 inserts bubble)
//  pco_sram_owner     out  1   0 = fetch owns instruction SRAM, 1 = MEM-stage data access
//  pco_stall_cnt      out  16  count of cycles with pco_pc_keep=1, saturates at 16'hFFFF
// BEHAVIOUR
//  - Outputs combinational from state + inputs (same-cycle), sampled by pipeline regs at next rising edge.
//  - Reset (pci_rst=0, immediate): state RUN, cnt 0, stall_cnt 0; outputs forced all keep=0, all en=1, owner=0.
//  - Default (no hazard): all keep=0, all en=1, owner=0. exmem_en is always 1 (no flush source at EX).
//  - conflict = pci_mem_rwe!=`RWE_IDLE && pci_mem_addr<IRAM_TOP (unsigned).
//  - lu (load-use) = pci_ex_rwe==`RWE_READ && pci_ex_wreg_addr!=`REG_INVALID &&
//    (pci_ex_wreg_addr==pci_id_rreg1 || pci_ex_wreg_addr==pci_id_rreg2).
//  - FREEZE outputs: pc/ifid/idex/exmem keep=1, memwb_en=0, other en=1.
//  - LAST outputs (final SRAM-data cycle): pc_keep=1, ifid_en=0 (fetch lost), owner=1; ID/EX, EX/MEM advance.
//  - LU outputs: pc_keep=1, ifid_keep=1, idex_en=0. Combined with LAST: ifid_keep=1, ifid_en=1 (keep wins;
//    the ID instruction is retained, no bubble into IF/ID), idex_en=0.
//  - FSM (cnt is a $clog2(MEM_CYCLES)+1-bit down-counter):
//    RUN : conflict && MEM_CYCLES>1 -> FREEZE, owner=1, cnt<=MEM_CYCLES-2, ->WAIT.
//          conflict && MEM_CYCLES==1 -> LAST (+LU if lu), stay RUN. else LU if lu, else default.
//    WAIT: owner=1. cnt!=0 -> FREEZE, cnt<=cnt-1. cnt==0 -> LAST (+LU if lu), ->RUN.
//  - pci_mem_busy=1 has top priority: FREEZE outputs, state and cnt held, owner keeps current value.
//  - lu is ignored while FREEZE outputs are driven (EX contents are held, so lu is re-evaluated later).
//  - Back-to-back conflicts: the cycle after LAST starts a new sequence if conflict is again true.
//  - stall_cnt increments on each rising edge where pco_pc_keep=1; no wrap, holds at 16'hFFFF.
//  - Reset asserted mid-WAIT aborts the sequence; the access is not resumed.
// TESTING
//  1. ex_rwe=01, ex_wreg=3, id_rreg1=3, one cycle -> pc_keep=1, ifid_keep=1, idex_en=0; stall_cnt 0->1.
//  2. ex_rwe=01, ex_wreg=4'hF, id_rreg1=4'hF -> no stall, all keep=0, en=1, stall_cnt stays 0.
//  3. MEM_CYCLES=3, mem_rwe=10, addr=16'h4000 -> cycles 1-2 FREEZE, cycle 3 pc_keep=1/ifid_en=0,
//     owner=1 for cycles 1-3, 0 in cycle 4; stall_cnt=3.
//  4. mem_rwe=01, addr=16'h8000 -> no conflict, owner=0, default outputs.
//  5. Test 3 with mem_busy=1 for 2 cycles during WAIT -> sequence lasts 5 cycles, LAST still occurs once.
//  6. Test 3, drop pci_rst in cycle 2 -> outputs default and owner=0 immediately; after release state RUN,
//     stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use and instruction-SRAM structural hazards,
// external memory wait freeze, and a saturating lost-fetch-cycle counter.
module pipeline_ctrl #(
  parameter int unsigned MEM_CYCLES = 2,
  parameter logic [15:0] IRAM_TOP   = 16'h8000
) (
  input  logic        pci_clk,
  input  logic        pci_rst,
  input  logic [3:0]  pci_id_rreg1,
  input  logic [3:0]  pci_id_rreg2,
  input  logic [3:0]  pci_ex_wreg_addr,
  input  logic [1:0]  pci_ex_rwe,
  input  logic [1:0]  pci_mem_rwe,
  input  logic [15:0] pci_mem_addr,
  input  logic        pci_mem_busy,
  output logic        pco_pc_keep,
  output logic        pco_ifid_keep,
  output logic        pco_ifid_en,
  output logic        pco_idex_keep,
  output logic        pco_idex_en,
  output logic        pco_exmem_keep,
  output logic        pco_exmem_en,
  output logic        pco_memwb_en,
  output logic        pco_sram_owner,
  output logic [15:0] pco_stall_cnt
);

  localparam logic [3:0] REG_INVALID = 4'hF;
  localparam logic [1:0] RWE_IDLE    = 2'b00;
  localparam logic [1:0] RWE_READ    = 2'b01;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int unsigned CW       = $clog2(MEM_CYCLES) + 1;
  localparam int unsigned INIT_VAL = (MEM_CYCLES > 1) ? MEM_CYCLES - 2 : 0;
  localparam logic [CW-1:0] CNT_INIT = CW'(INIT_VAL);
  localparam bit MULTI = (MEM_CYCLES > 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic conflict, lu;
  logic freeze, last, lu_act, owner;

  assign conflict = (pci_mem_rwe != RWE_IDLE) && (pci_mem_addr < IRAM_TOP);
  assign lu = (pci_ex_rwe == RWE_READ) && (pci_ex_wreg_addr != REG_INVALID) &&
              ((pci_ex_wreg_addr == pci_id_rreg1) || (pci_ex_wreg_addr == pci_id_rreg2));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    last    = 1'b0;
    lu_act  = 1'b0;
    owner   = 1'b0;
    if (pci_mem_busy) begin
      // Whole pipeline frozen; SRAM ownership follows whatever access is in flight.
      freeze = 1'b1;
      owner  = (state_q == ST_WAIT);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (conflict) begin
            owner = 1'b1;
            if (MULTI) begin
              freeze  = 1'b1;
              cnt_d   = CNT_INIT;
              state_d = ST_WAIT;
            end else begin
              last   = 1'b1;
              lu_act = lu;
            end
          end else begin
            lu_act = lu;
          end
        end
        ST_WAIT: begin
          owner = 1'b1;
          if (cnt_q != '0) begin
            freeze = 1'b1;
            cnt_d  = cnt_q - 1'b1;
          end else begin
            last    = 1'b1;
            lu_act  = lu;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pco_pc_keep    = freeze | last | lu_act;
    pco_ifid_keep  = freeze | lu_act;
    // A load-use hold keeps the ID instruction, so the lost fetch need not be flushed into IF/ID.
    pco_ifid_en    = !(last && !lu_act);
    pco_idex_keep  = freeze;
    pco_idex_en    = !lu_act;
    pco_exmem_keep = freeze;
    pco_exmem_en   = 1'b1;
    pco_memwb_en   = !freeze;
    pco_sram_owner = owner;
    if (!pci_rst) begin
      pco_pc_keep    = 1'b0;
      pco_ifid_keep  = 1'b0;
      pco_ifid_en    = 1'b1;
      pco_idex_keep  = 1'b0;
      pco_idex_en    = 1'b1;
      pco_exmem_keep = 1'b0;
      pco_exmem_en   = 1'b1;
      pco_memwb_en   = 1'b1;
      pco_sram_owner = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pco_pc_keep && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge pci_clk or negedge pci_rst) begin
    if (!pci_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pco_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: MEM_CYCLES=3 instance for the main tests, MEM_CYCLES=1 instance
// for the single-cycle structural conflict path.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id_rreg1, id_rreg2, ex_wreg;
  logic [1:0]  ex_rwe, mem_rwe;
  logic [15:0] mem_addr;
  logic        mem_busy;

  logic        pc_keep3, ifid_keep3, ifid_en3, idex_keep3, idex_en3, exmem_keep3, exmem_en3, memwb_en3, owner3;
  logic [15:0] stall3;
  logic        pc_keep1, ifid_keep1, ifid_en1, idex_keep1, idex_en1, exmem_keep1, exmem_en1, memwb_en1, owner1;
  logic [15:0] stall1;

  int checks = 0;
  int errors = 0;

  // {pc_keep, ifid_keep, ifid_en, idex_keep, idex_en, exmem_keep, exmem_en, memwb_en, owner}
  localparam logic [8:0] DEF    = 9'b0_0_1_0_1_0_1_1_0;
  localparam logic [8:0] FRZ_O1 = 9'b1_1_1_1_1_1_1_0_1;
  localparam logic [8:0] FRZ_O0 = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] LAST   = 9'b1_0_0_0_1_0_1_1_1;
  localparam logic [8:0] LU     = 9'b1_1_1_0_0_0_1_1_0;
  localparam logic [8:0] LASTLU = 9'b1_1_1_0_0_0_1_1_1;

  logic [8:0] o3, o1;
  assign o3 = {pc_keep3, ifid_keep3, ifid_en3, idex_keep3, idex_en3, exmem_keep3, exmem_en3, memwb_en3, owner3};
  assign o1 = {pc_keep1, ifid_keep1, ifid_en1, idex_keep1, idex_en1, exmem_keep1, exmem_en1, memwb_en1, owner1};

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_CYCLES(3), .IRAM_TOP(16'h8000)) dut3 (
    .pci_clk(clk), .pci_rst(rst_n),
    .pci_id_rreg1(id_rreg1), .pci_id_rreg2(id_rreg2), .pci_ex_wreg_addr(ex_wreg),
    .pci_ex_rwe(ex_rwe), .pci_mem_rwe(mem_rwe), .pci_mem_addr(mem_addr), .pci_mem_busy(mem_busy),
    .pco_pc_keep(pc_keep3), .pco_ifid_keep(ifid_keep3), .pco_ifid_en(ifid_en3),
    .pco_idex_keep(idex_keep3), .pco_idex_en(idex_en3), .pco_exmem_keep(exmem_keep3),
    .pco_exmem_en(exmem_en3), .pco_memwb_en(memwb_en3), .pco_sram_owner(owner3),
    .pco_stall_cnt(stall3)
  );

  pipeline_ctrl #(.MEM_CYCLES(1), .IRAM_TOP(16'h8000)) dut1 (
    .pci_clk(clk), .pci_rst(rst_n),
    .pci_id_rreg1(id_rreg1), .pci_id_rreg2(id_rreg2), .pci_ex_wreg_addr(ex_wreg),
    .pci_ex_rwe(ex_rwe), .pci_mem_rwe(mem_rwe), .pci_mem_addr(mem_addr), .pci_mem_busy(mem_busy),
    .pco_pc_keep(pc_keep1), .pco_ifid_keep(ifid_keep1), .pco_ifid_en(ifid_en1),
    .pco_idex_keep(idex_keep1), .pco_idex_en(idex_en1), .pco_exmem_keep(exmem_keep1),
    .pco_exmem_en(exmem_en1), .pco_memwb_en(memwb_en1), .pco_sram_owner(owner1),
    .pco_stall_cnt(stall1)
  );

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s obs=%b exp=%b", tag, obs, exp);
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s obs=%0d exp=%0d", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    id_rreg1 = 4'hF; id_rreg2 = 4'hF; ex_wreg = 4'hF;
    ex_rwe = 2'b00; mem_rwe = 2'b00; mem_addr = 16'h0000; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Apply inputs at the falling edge; outputs are combinational, so sample 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk9("reset_outs", o3, DEF);
    chk16("reset_cnt", stall3, 16'd0);
    rst_n = 1'b1;

    // Test 1: load-use on rreg1
    step(); ex_rwe = 2'b01; ex_wreg = 4'd3; id_rreg1 = 4'd3; #1;
    chk9("lu_outs", o3, LU);
    chk16("lu_cnt_pre", stall3, 16'd0);
    step(); idle_inputs(); #1;
    chk16("lu_cnt_post", stall3, 16'd1);
    chk9("lu_release", o3, DEF);

    // Test 2: invalid destination never stalls
    do_reset();
    step(); ex_rwe = 2'b01; ex_wreg = 4'hF; id_rreg1 = 4'hF; #1;
    chk9("inv_outs", o3, DEF);
    step(); idle_inputs(); #1;
    chk16("inv_cnt", stall3, 16'd0);

    // Test 3: 3-cycle structural conflict
    do_reset();
    step(); mem_rwe = 2'b10; mem_addr = 16'h4000; #1;
    chk9("t3_c1", o3, FRZ_O1);
    chk9("t3_mc1_last", o1, LAST);
    step(); #1;
    chk9("t3_c2", o3, FRZ_O1);
    step(); #1;
    chk9("t3_c3", o3, LAST);
    step(); mem_rwe = 2'b00; #1;
    chk9("t3_c4", o3, DEF);
    chk16("t3_cnt", stall3, 16'd3);
    chk16("t3_mc1_cnt", stall1, 16'd3);

    // Test 4: address at IRAM_TOP is not a conflict; one below is
    do_reset();
    step(); mem_rwe = 2'b01; mem_addr = 16'h8000; #1;
    chk9("t4_top", o3, DEF);
    mem_addr = 16'h7FFF; #1;
    chk9("t4_below_mc1", o1, LAST);
    step(); mem_rwe = 2'b00; #1;
    chk9("t4_mc1_after", o1, DEF);

    // Busy while RUN with no access in flight: freeze, owner stays fetch
    do_reset();
    step(); mem_busy = 1'b1; ex_rwe = 2'b01; ex_wreg = 4'd2; id_rreg2 = 4'd2; #1;
    chk9("busy_run", o3, FRZ_O0);
    step(); idle_inputs(); #1;
    chk16("busy_run_cnt", stall3, 16'd1);

    // Test 5: busy for 2 cycles during WAIT, load-use ignored while frozen, LAST+LU at the end
    do_reset();
    step(); mem_rwe = 2'b10; mem_addr = 16'h4000; #1;
    chk9("t5_c1", o3, FRZ_O1);
    step(); mem_busy = 1'b1; #1;
    chk9("t5_c2_busy", o3, FRZ_O1);
    step(); ex_rwe = 2'b01; ex_wreg = 4'd5; id_rreg2 = 4'd5; #1;
    chk9("t5_c3_busy_lu", o3, FRZ_O1);
    step(); mem_busy = 1'b0; #1;
    chk9("t5_c4", o3, FRZ_O1);
    step(); #1;
    chk9("t5_c5_lastlu", o3, LASTLU);
    step(); mem_rwe = 2'b00; ex_rwe = 2'b00; #1;
    chk9("t5_c6", o3, DEF);
    chk16("t5_cnt", stall3, 16'd5);

    // Back-to-back conflicts: conflict still true after LAST restarts the sequence
    do_reset();
    step(); mem_rwe = 2'b01; mem_addr = 16'h0010; #1;
    step(); step(); #1;
    chk9("b2b_last", o3, LAST);
    step(); #1;
    chk9("b2b_restart", o3, FRZ_O1);
    step(); idle_inputs(); #1;
    chk9("b2b_wait", o3, FRZ_O1);

    // Test 6: reset in the middle of WAIT aborts the access
    do_reset();
    step(); mem_rwe = 2'b10; mem_addr = 16'h4000; #1;
    chk9("t6_c1", o3, FRZ_O1);
    step(); #1;
    chk9("t6_c2", o3, FRZ_O1);
    #2 rst_n = 1'b0; #1;
    chk9("t6_rst_outs", o3, DEF);
    chk16("t6_rst_cnt", stall3, 16'd0);
    mem_rwe = 2'b00;
    step(); rst_n = 1'b1; #1;
    chk9("t6_after", o3, DEF);
    step(); #1;
    chk16("t6_cnt_after", stall3, 16'd0);
    chk9("t6_run", o3, DEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
